mem_interface: RTL and testbench
================================

MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- wordSize, 32, data width.
- addrWidth, 9, memory address width.
- TIMEOUT, 15, maximum wait cycles for mem_ack.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock  in  1  single clock; all state changes on the rising edge.
- clear  in  1  reset, synchronous, active-high.
- BusMuxOut  in  wordSize  bus value.
- MARin  in  1  load MAR from the bus.
- MDRin  in  1  load MDR from the bus.
- MemRead  in  1  start a memory read.
- MemWrite  in  1  start a memory write.
- mem_rdata  in  wordSize  memory read data.
- mem_ack  in  1  memory completion.
- mem_addr  out  addrWidth  equals MAR.
- mem_wdata  out  wordSize  equals MDR.
- mem_req  out  1  transaction request.
- mem_we  out  1  1 = write, 0 = read.
- BusMuxIn_MDR  out  wordSize  MDR contents, fed to the bus mux.
- mem_busy  out  1  transaction in progress.
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  sticky error flag.
REQ-003 Reset is synchronous and active-high on clear; single clock domain (clock).

Function
REQ-004 FSM states: IDLE, RD, WR, DONE; all outputs are registered or decoded only from state and registers.
REQ-005 IDLE with MARin=1: MAR <= BusMuxOut[addrWidth-1:0] on the same edge.
REQ-006 IDLE with MDRin=1: MDR <= BusMuxOut.
REQ-007 IDLE with MemRead=1 and MemWrite=0: go to RD; mem_req=1 and mem_we=0 from the next cycle.
REQ-008 IDLE with MemWrite=1 and MemRead=0: go to WR; mem_req=1 and mem_we=1 from the next cycle.
REQ-009 MemRead and MemWrite sampled together in IDLE: no transaction starts, mem_err <= 1, state stays IDLE.
REQ-010 Register loads versus transaction start on the same IDLE edge:
- MARin/MDRin loads take effect on that edge.
- The transaction uses the newly loaded MAR/MDR values.
REQ-011 RD completion: on the edge where mem_ack=1, MDR <= mem_rdata and state goes to DONE.
REQ-012 WR completion: on the edge where mem_ack=1, state goes to DONE; MDR is unchanged.
REQ-013 DONE lasts exactly one cycle with mem_done=1, mem_req=0 and mem_busy=0, then returns to IDLE.
REQ-014 Total latency: MemRead sampled at edge 0 and mem_ack at edge k gives mem_done high in cycle k+1; minimum k=1.
REQ-015 mem_busy=1 exactly in RD and WR.
REQ-016 Inputs ignored while in RD, WR or DONE: MARin, MDRin, MemRead and MemWrite.
REQ-017 mem_ack is ignored in IDLE and DONE.
REQ-018 Timeout counter:
- Cleared on entry to RD/WR; increments each cycle without mem_ack.
- On reaching TIMEOUT without mem_ack: mem_err <= 1, state goes to DONE (mem_done pulses), MDR unchanged.
REQ-019 mem_ack arriving on the same edge the counter reaches TIMEOUT counts as success; no error is raised.
REQ-020 mem_err clears only on clear.
REQ-021 mem_addr equals MAR and mem_wdata equals MDR at all times; BusMuxIn_MDR equals MDR.

Reset
REQ-022 clear=1 at a rising edge sets:
- State IDLE.
- MAR=0, MDR=0, counter=0.
- mem_req=0, mem_we=0, mem_busy=0, mem_done=0, mem_err=0.
REQ-023 clear during RD or WR abandons the transaction, with no mem_done pulse; clear takes priority over every other input on that edge.

Structure
REQ-024 Shared package cpu_defs_pkg holds:
- The FSM state encoding (2 bits).
- Default wordSize, addrWidth and TIMEOUT constants.
REQ-025 Sub-module mem_timeout_counter has ports clock, clear, start, enable and expired, and is sized by ceil(log2(TIMEOUT+1)).

Verification
REQ-026 Basic read: MARin with bus=0x0000_0005, then MemRead, memory model acks 3 cycles later with 0xDEAD_BEEF.
- mem_addr=5 throughout.
- MDR=0xDEAD_BEEF.
- mem_done pulses once, one cycle after the ack.
REQ-027 Basic write: MDRin with bus=0x1234_5678, MARin with 0x1FF, then MemWrite, ack after 1 cycle.
- mem_we=1, mem_wdata=0x1234_5678, mem_addr=0x1FF while mem_req=1.
- MDR unchanged afterwards.
REQ-028 Timeout: MemRead with no ack.
- mem_busy high for exactly 15 cycles.
- mem_err=1, mem_done pulses once, MDR retains its previous value.
REQ-029 Conflict and ignore cases:
- MemRead and MemWrite together: mem_err=1, mem_req stays 0.
- MDRin asserted during RD: MDR is unchanged until the ack.
REQ-030 Reset mid-operation: clear during WR.
- Next cycle: all outputs are at their reset values.
- A late mem_ack has no effect.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs_pkg
// Purpose  : Shared FSM encoding and default sizing for the memory interface.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    localparam int c_word_size  = 32;
    localparam int c_addr_width = 9;
    localparam int c_timeout    = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

endpackage : cpu_defs_pkg
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_counter
// Purpose  : Counts wait cycles of a memory transaction; flags the final one.
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (clear || start) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Asserted on the edge that would bring the count up to TIMEOUT.
    assign expired = enable && (r_count == c_last);

endmodule : mem_timeout_counter
`default_nettype wire

// File: rtl/mem_interface.sv
`default_nettype none
// ============================================================================
// Module   : mem_interface
// Purpose  : MAR/MDR register pair and memory handshake FSM with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_interface
    import cpu_defs_pkg::*;
#(
    parameter int wordSize  = c_word_size,
    parameter int addrWidth = c_addr_width,
    parameter int TIMEOUT   = c_timeout
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [wordSize-1:0]  BusMuxOut,
    input  logic                 MARin,
    input  logic                 MDRin,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [wordSize-1:0]  mem_rdata,
    input  logic                 mem_ack,
    output logic [addrWidth-1:0] mem_addr,
    output logic [wordSize-1:0]  mem_wdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [wordSize-1:0]  BusMuxIn_MDR,
    output logic                 mem_busy,
    output logic                 mem_done,
    output logic                 mem_err
);

    mem_state_t          r_state;
    mem_state_t          w_next;
    logic [addrWidth-1:0] r_mar;
    logic [wordSize-1:0]  r_mdr;
    logic                 r_err;
    logic                 w_idle;
    logic                 w_active;
    logic                 w_start;
    logic                 w_expired;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_active = (r_state == ST_RD) || (r_state == ST_WR);
    assign w_start  = w_idle && (MemRead ^ MemWrite);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .clear   (clear),
        .start   (w_start),
        .enable  (w_active && !mem_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (MemRead && !MemWrite) begin
                    w_next = ST_RD;
                end else if (MemWrite && !MemRead) begin
                    w_next = ST_WR;
                end
            end
            ST_RD, ST_WR: begin
                if (mem_ack || w_expired) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = w_active;
        mem_busy = w_active;
        mem_we   = (r_state == ST_WR);
        mem_done = (r_state == ST_DONE);
    end

    // Register loads land on the same edge a transaction starts, so the
    // transaction sees the freshly loaded MAR/MDR on its first cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_mar <= '0;
            r_mdr <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_idle) begin
                if (MARin) begin
                    r_mar <= BusMuxOut[addrWidth-1:0];
                end
                if (MDRin) begin
                    r_mdr <= BusMuxOut;
                end
                if (MemRead && MemWrite) begin
                    r_err <= 1'b1;
                end
            end
            if ((r_state == ST_RD) && mem_ack) begin
                r_mdr <= mem_rdata;
            end
            // Ack wins over expiry on the same edge.
            if (w_active && !mem_ack && w_expired) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_addr     = r_mar;
    assign mem_wdata    = r_mdr;
    assign BusMuxIn_MDR = r_mdr;
    assign mem_err      = r_err;

endmodule : mem_interface
`default_nettype wire

// File: tb/tb_mem_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_interface
// Purpose  : Directed self-checking bench for mem_interface.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_interface;

    localparam int WS = 32;
    localparam int AW = 9;

    logic          clock = 1'b0;
    logic          clear;
    logic [WS-1:0] BusMuxOut;
    logic          MARin, MDRin, MemRead, MemWrite;
    logic [WS-1:0] mem_rdata;
    logic          mem_ack;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_wdata, BusMuxIn_MDR;
    logic          mem_req, mem_we, mem_busy, mem_done, mem_err;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cycles;

    always #5 clock = ~clock;

    mem_interface #(
        .wordSize  (WS),
        .addrWidth (AW),
        .TIMEOUT   (15)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .BusMuxOut    (BusMuxOut),
        .MARin        (MARin),
        .MDRin        (MDRin),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .BusMuxIn_MDR (BusMuxIn_MDR),
        .mem_busy     (mem_busy),
        .mem_done     (mem_done),
        .mem_err      (mem_err)
    );

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},  64'(mem_req),  64'd0);
        check({tag, "_we"},   64'(mem_we),   64'd0);
        check({tag, "_busy"}, 64'(mem_busy), 64'd0);
        check({tag, "_done"}, 64'(mem_done), 64'd0);
    endtask

    initial begin
        clear = 1'b1; BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        clear = 1'b0;
        check_idle_outputs("rst");
        check("rst_err",  64'(mem_err),      64'd0);
        check("rst_addr", 64'(mem_addr),     64'd0);
        check("rst_mdr",  64'(BusMuxIn_MDR), 64'd0);

        // Basic read, ack three cycles after the start edge
        BusMuxOut = 32'h0000_0005; MARin = 1'b1;
        tick();
        MARin = 1'b0;
        check("rd_mar", 64'(mem_addr), 64'h5);
        MemRead = 1'b1; mem_ack = 1'b1;
        tick();
        MemRead = 1'b0; mem_ack = 1'b0;
        check("rd_req",  64'(mem_req),  64'd1);
        check("rd_we",   64'(mem_we),   64'd0);
        check("rd_busy", 64'(mem_busy), 64'd1);
        tick(); tick();
        check("rd_wait_busy", 64'(mem_busy), 64'd1);
        check("rd_addr",      64'(mem_addr), 64'h5);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("rd_done",     64'(mem_done),     64'd1);
        check("rd_done_req", 64'(mem_req),      64'd0);
        check("rd_mdr",      64'(BusMuxIn_MDR), 64'hDEAD_BEEF);
        check("rd_done_adr", 64'(mem_addr),     64'h5);
        tick();
        check("rd_done_once", 64'(mem_done), 64'd0);
        check("rd_err",       64'(mem_err),  64'd0);

        // Basic write, ack after one cycle
        BusMuxOut = 32'h1234_5678; MDRin = 1'b1;
        tick();
        MDRin = 1'b0; BusMuxOut = 32'h0000_01FF; MARin = 1'b1;
        tick();
        MARin = 1'b0; MemWrite = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        tick();
        MemWrite = 1'b0;
        check("wr_req",   64'(mem_req),   64'd1);
        check("wr_we",    64'(mem_we),    64'd1);
        check("wr_wdata", 64'(mem_wdata), 64'h1234_5678);
        check("wr_addr",  64'(mem_addr),  64'h1FF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wr_done", 64'(mem_done),     64'd1);
        check("wr_mdr",  64'(BusMuxIn_MDR), 64'h1234_5678);
        tick();

        // Ack on the very edge the timeout would fire: success, no error
        MemRead = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        MemRead = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("edge_busy", 64'(mem_busy), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("edge_done", 64'(mem_done),     64'd1);
        check("edge_err",  64'(mem_err),      64'd0);
        check("edge_mdr",  64'(BusMuxIn_MDR), 64'hCAFE_F00D);
        tick();

        // Timeout with same-edge MAR load; MDRin during RD must be ignored
        BusMuxOut = 32'h0000_00AB; MARin = 1'b1; MemRead = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        MARin = 1'b0; MemRead = 1'b0;
        check("to_new_mar", 64'(mem_addr), 64'hAB);
        MDRin = 1'b1; BusMuxOut = 32'h7777_7777;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_busy) break;
            busy_cycles++;
            tick();
        end
        MDRin = 1'b0;
        check("to_busy_cycles", 64'(busy_cycles),  64'd15);
        check("to_done",        64'(mem_done),     64'd1);
        check("to_err",         64'(mem_err),      64'd1);
        check("to_mdr",         64'(BusMuxIn_MDR), 64'hCAFE_F00D);
        tick();
        check("to_done_once", 64'(mem_done), 64'd0);
        check("to_err_sticky", 64'(mem_err), 64'd1);

        // Conflicting requests
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_err", 64'(mem_err), 64'd0);
        MemRead = 1'b1; MemWrite = 1'b1;
        tick();
        MemRead = 1'b0; MemWrite = 1'b0;
        check("cf_err", 64'(mem_err), 64'd1);
        check("cf_req", 64'(mem_req), 64'd0);
        tick();
        check("cf_req_later", 64'(mem_req), 64'd0);

        // Clear during a write, then a late ack
        clear = 1'b1;
        tick();
        clear = 1'b0;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        check("mid_we", 64'(mem_we), 64'd1);
        clear = 1'b1; mem_ack = 1'b1;
        tick();
        clear = 1'b0;
        check_idle_outputs("mid_rst");
        check("mid_err",  64'(mem_err),      64'd0);
        check("mid_addr", 64'(mem_addr),     64'd0);
        check("mid_mdr",  64'(BusMuxIn_MDR), 64'd0);
        tick();
        mem_ack = 1'b0;
        check_idle_outputs("late_ack");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_interface
`default_nettype wire
